// File: rtl/pipe_alu_param_pkg.sv
// Shared opcode constants and default widths for the pipelined ALU block.
// Latency: n/a (declarations only). Backpressure: n/a.
package pipe_alu_param_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;
  localparam int MW_DEF = 8;

  // Codes 12-15 are deliberately unassigned and evaluate to zero.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_SELA = 4'd3,
    OP_SELB = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NEGA = 4'd8,
    OP_NEGB = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLA  = 4'd11
  } alu_op_e;

endpackage

// File: rtl/pipe_alu_param_alu.sv
// Combinational DW-bit ALU; all arithmetic wraps modulo 2**DW, no flags.
// Latency: 0 cycles. Backpressure: none (pure logic).
module pipe_alu
  import pipe_alu_param_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    func,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    case (func)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_SELA: result = a;
      OP_SELB: result = b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NEGA: result = -a;
      OP_NEGB: result = -b;
      // Despite the mnemonic this is a logical shift: the MSB fills with 0.
      OP_SRA:  result = a >> 1;
      OP_SLA:  result = a << 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_alu_param.sv
// Three-stage ALU pipe (capture, execute into z, writeback to regbank+mem); z one cycle after accept, WB two.
// No output backpressure; PIPE_FWD_EN selects RAW forwarding, otherwise in_ready drops until the hazard retires.
module pipe_alu_param
  import pipe_alu_param_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [MW-1:0] addr,
  output logic [DW-1:0] z,
  output logic          z_valid,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_idx,
  input  logic [DW-1:0] ld_data,
  input  logic [MW-1:0] mem_raddr,
  output logic [DW-1:0] mem_rdata
);

  localparam int NREG   = 1 << AW;
  localparam int MDEPTH = 1 << MW;

  logic [DW-1:0] rf_q  [NREG];
  logic [DW-1:0] mem_q [MDEPTH];

  logic          s1_vld_q;
  logic [DW-1:0] s1_a_q, s1_b_q;
  logic [3:0]    s1_func_q;
  logic [AW-1:0] s1_rd_q;
  logic [MW-1:0] s1_addr_q;

  logic          s2_vld_q;
  logic [DW-1:0] z_q;
  logic [AW-1:0] s2_rd_q;
  logic [MW-1:0] s2_addr_q;

  logic [DW-1:0] mem_rdata_q;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] s1_a_d, s1_b_d;
  logic          s1_vld_d;
  logic          stall;
  logic          hit1_s1, hit1_s2, hit2_s1, hit2_s2;

  pipe_alu #(.DW(DW)) u_alu (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .func   (s1_func_q),
    .result (alu_res)
  );

  assign hit1_s1 = s1_vld_q && (s1_rd_q == rs1);
  assign hit2_s1 = s1_vld_q && (s1_rd_q == rs2);
  assign hit1_s2 = s2_vld_q && (s2_rd_q == rs1);
  assign hit2_s2 = s2_vld_q && (s2_rd_q == rs2);

`ifdef PIPE_FWD_EN
  // Youngest producer wins: S1 result beats the value about to be written from S2.
  always_comb begin
    s1_a_d = rf_q[rs1];
    s1_b_d = rf_q[rs2];
    if (hit1_s2) s1_a_d = z_q;
    if (hit2_s2) s1_b_d = z_q;
    if (hit1_s1) s1_a_d = alu_res;
    if (hit2_s1) s1_b_d = alu_res;
  end

  assign stall = 1'b0;
`else
  assign s1_a_d = rf_q[rs1];
  assign s1_b_d = rf_q[rs2];
  assign stall  = hit1_s1 || hit1_s2 || hit2_s1 || hit2_s2;
`endif

  assign in_ready  = !rst && !stall;
  assign s1_vld_d  = in_valid && in_ready;
  assign z         = z_q;
  assign z_valid   = s2_vld_q;
  assign mem_rdata = mem_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_func_q <= '0;
      s1_rd_q   <= '0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      z_q       <= '0;
      s2_rd_q   <= '0;
      s2_addr_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_func_q <= func;
        s1_rd_q   <= rd;
        s1_addr_q <= addr;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        z_q       <= alu_res;
        s2_rd_q   <= s1_rd_q;
        s2_addr_q <= s1_addr_q;
      end
    end
  end

  // Writeback is ordered after the preload so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (ld_we)    rf_q[ld_idx]  <= ld_data;
      if (s2_vld_q) rf_q[s2_rd_q] <= z_q;
    end
  end

  // Memory contents survive reset; only the in-flight write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && s2_vld_q) mem_q[s2_addr_q] <= z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_rdata_q <= '0;
    else     mem_rdata_q <= mem_q[mem_raddr];
  end

endmodule

// File: tb/tb_pipe_alu_param.sv
// Directed bench for pipe_alu_param: opcode vector table plus hazard, WB-priority and reset sequences.
module tb_pipe_alu_param;
  import pipe_alu_param_pkg::*;

`ifdef PIPE_FWD_EN
  localparam int STALL_S1 = 0;
  localparam int STALL_S2 = 0;
`else
  localparam int STALL_S1 = 2;
  localparam int STALL_S2 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, mem_raddr;
  logic [15:0] z, ld_data, mem_rdata;
  logic        z_valid, ld_we;
  logic [3:0]  ld_idx;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_alu_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .z(z), .z_valid(z_valid),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    ld_we = 1'b1; ld_idx = idx; ld_data = val;
    tick();
    ld_we = 1'b0;
  endtask

  // Returns at the negedge following the accept edge; st counts stalled cycles.
  task automatic issue(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] d, input logic [7:0] ad, output int st);
    func = f; rs1 = a1; rs2 = a2; rd = d; addr = ad; in_valid = 1'b1; st = 0;
    #1;
    while (!in_ready && st < 20) begin
      tick(); #1; st++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_wait: in_ready stuck at 0, required 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_z(input string nm, input logic [15:0] exp);
    tick();
    check({nm, "_zvalid"}, z_valid, 1);
    check(nm, z, exp);
  endtask

  // Reads a register through a SEL A that writes the same value back (scratch mem 255).
  task automatic read_reg(input string nm, input logic [3:0] idx, input logic [15:0] exp);
    int st;
    issue(OP_SELA, idx, idx, idx, 8'hFF, st);
    expect_z(nm, exp);
    tick();
  endtask

  task automatic read_mem(input string nm, input logic [7:0] a, input logic [15:0] exp);
    mem_raddr = a;
    tick();
    check(nm, mem_rdata, exp);
  endtask

  initial begin
    int st;
    vecs[0]  = '{"add",    OP_ADD,  16'd3,      16'd5,      16'd8};
    vecs[1]  = '{"sub",    OP_SUB,  16'd3,      16'd5,      16'hFFFE};
    vecs[2]  = '{"mul",    OP_MUL,  16'd3,      16'd8,      16'd24};
    vecs[3]  = '{"sela",   OP_SELA, 16'd7,      16'd9,      16'd7};
    vecs[4]  = '{"selb",   OP_SELB, 16'd7,      16'd9,      16'd9};
    vecs[5]  = '{"and",    OP_AND,  16'hF0F0,   16'hFF00,   16'hF000};
    vecs[6]  = '{"or",     OP_OR,   16'hF0F0,   16'h0F0F,   16'hFFFF};
    vecs[7]  = '{"xor",    OP_XOR,  16'hFFFF,   16'h1234,   16'hEDCB};
    vecs[8]  = '{"nega",   OP_NEGA, 16'd1,      16'd2,      16'hFFFF};
    vecs[9]  = '{"negb",   OP_NEGB, 16'd1,      16'd2,      16'hFFFE};
    vecs[10] = '{"sra",    OP_SRA,  16'h8001,   16'd0,      16'h4000};
    vecs[11] = '{"sla",    OP_SLA,  16'd7,      16'd0,      16'd14};
    vecs[12] = '{"sla_msb",OP_SLA,  16'h8001,   16'd0,      16'h0002};
    vecs[13] = '{"f12",    4'd12,   16'h1234,   16'h5678,   16'd0};
    vecs[14] = '{"f13",    4'd13,   16'h1234,   16'h5678,   16'd0};
    vecs[15] = '{"f15",    4'd15,   16'hFFFF,   16'hFFFF,   16'd0};
    vecs[16] = '{"add_wrap",OP_ADD, 16'hFFFF,   16'd1,      16'd0};
    vecs[17] = '{"mul_wrap",OP_MUL, 16'h0100,   16'h0100,   16'd0};

    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
    ld_we = 1'b0; ld_idx = '0; ld_data = '0; mem_raddr = '0;
    repeat (3) tick();
    in_valid = 1'b1; #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_z", z, 0);
    check("rst_z_valid", z_valid, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    in_valid = 1'b0; rst = 1'b0;
    tick(); #1;
    check("idle_in_ready", in_ready, 1);

    for (int k = 0; k < 16; k++) preload(4'(k), 16'(k));

    // Basic ADD with writeback to register and memory.
    issue(OP_ADD, 4'd3, 4'd5, 4'd10, 8'd125, st);
    check("add_stall", st, 0);
    expect_z("add_z", 16'd8);
    tick();
    check("add_zvalid_drop", z_valid, 0);
    read_reg("add_r10", 4'd10, 16'd8);
    read_mem("add_mem125", 8'd125, 16'd8);

    // Back-to-back dependency through S1.
    issue(OP_ADD, 4'd3, 4'd5, 4'd10, 8'd125, st);
    issue(OP_SUB, 4'd10, 4'd5, 4'd14, 8'd128, st);
    check("raw_s1_stall", st, STALL_S1);
    expect_z("raw_s1_z", 16'd3);
    tick();
    read_mem("raw_s1_mem128", 8'd128, 16'd3);
    read_reg("raw_s1_r14", 4'd14, 16'd3);

    // Dependency two instructions back (producer in S2).
    preload(4'd10, 16'h0000);
    issue(OP_ADD, 4'd3, 4'd5, 4'd10, 8'd129, st);
    issue(OP_SELA, 4'd1, 4'd1, 4'd1, 8'd254, st);
    issue(OP_SUB, 4'd10, 4'd5, 4'd14, 8'd130, st);
    check("raw_s2_stall", st, STALL_S2);
    expect_z("raw_s2_z", 16'd3);
    tick();
    read_mem("raw_s2_mem130", 8'd130, 16'd3);

    issue(OP_MUL, 4'd3, 4'd8, 4'd12, 8'd131, st);
    expect_z("mul_z", 16'd24);
    tick();
    read_reg("mul_r12", 4'd12, 16'd24);

    // Preload and writeback land on r10 at the same edge; writeback must win.
    preload(4'd10, 16'h1111);
    issue(OP_ADD, 4'd3, 4'd5, 4'd10, 8'd140, st);
    expect_z("wbld_z", 16'd8);
    ld_we = 1'b1; ld_idx = 4'd10; ld_data = 16'h5555;
    tick();
    ld_we = 1'b0;
    read_reg("wbld_r10", 4'd10, 16'd8);

    // Read of an address written at the same edge returns old data.
    preload(4'd4, 16'h0099);
    issue(OP_SELA, 4'd4, 4'd4, 4'd4, 8'd125, st);
    tick();
    mem_raddr = 8'd125;
    tick();
    check("rdw_old", mem_rdata, 16'd8);
    tick();
    check("rdw_new", mem_rdata, 16'h0099);

    foreach (vecs[i]) begin
      preload(4'd1, vecs[i].a);
      preload(4'd2, vecs[i].b);
      issue(vecs[i].f, 4'd1, 4'd2, 4'd3, 8'd200, st);
      expect_z(vecs[i].name, vecs[i].exp);
      tick();
      check({vecs[i].name, "_single"}, z_valid, 0);
    end

    // Reset one cycle after accept discards the instruction.
    preload(4'd3, 16'h0020);
    preload(4'd5, 16'h0022);
    issue(OP_ADD, 4'd3, 4'd5, 4'd10, 8'd125, st);
    rst = 1'b1;
    tick(); #1;
    check("mrst_z_valid", z_valid, 0);
    check("mrst_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mrst_no_z", z_valid, 0);
    end
    read_mem("mrst_mem125", 8'd125, 16'h0099);
    read_reg("mrst_r10", 4'd10, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
